alu_muldiv_seq: RTL

//  Execute-stage ALU, WIDTH-parametrised. Single-cycle ops: add/sub/or/and/slt/sltu.

---
 rtl/alu_muldiv_seq.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/alu_muldiv_seq.sv
// Execute-stage ALU: single-cycle integer ops plus iterative multiply/divide into HI/LO.
// Iterative ops stall the input handshake; flush squashes the op in flight.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] lvalue,
  input  logic [WIDTH-1:0] rvalue,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic             bad_op
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_OR    = 4'd2, OP_AND  = 4'd3,
    OP_SLT  = 4'd4,  OP_SLTU = 4'd5,  OP_MULT  = 4'd6, OP_MULTU = 4'd7,
    OP_DIV  = 4'd8,  OP_DIVU = 4'd9,  OP_MFHI  = 4'd10, OP_MFLO = 4'd11
  } op_t;

  state_t           state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] opnd;        // multiplicand or divisor magnitude
  logic [WIDTH-1:0] p_hi, p_lo;  // partial product / remainder and quotient
  logic             neg_q, neg_r, op_div, dz;

  logic             accept, is_mul, is_div, is_iter, is_signed, l_neg, r_neg;
  logic [WIDTH-1:0] l_mag, r_mag, alu_res;
  logic [WIDTH:0]   mul_sum;
  logic             div_ge;
  logic [WIDTH:0]   div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign in_ready  = (state == S_IDLE);
  assign accept    = in_valid & in_ready & ~flush;
  assign is_mul    = (alu_op == OP_MULT) || (alu_op == OP_MULTU);
  assign is_div    = (alu_op == OP_DIV)  || (alu_op == OP_DIVU);
  assign is_iter   = is_mul | is_div;
  assign is_signed = (alu_op == OP_MULT) || (alu_op == OP_DIV);
  assign l_neg     = is_signed & lvalue[WIDTH-1];
  assign r_neg     = is_signed & rvalue[WIDTH-1];
  assign l_mag     = l_neg ? -lvalue : lvalue;
  assign r_mag     = r_neg ? -rvalue : rvalue;

  // Shift-add step: the multiplier sits in p_lo and is consumed from bit 0.
  assign mul_sum   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opnd} : '0);
  // Restoring step: remainder stays below the divisor, so WIDTH+1 bits suffice.
  assign div_ge    = {p_hi, p_lo[WIDTH-1]} >= {1'b0, opnd};
  assign div_trial = {p_hi, p_lo[WIDTH-1]} - {1'b0, opnd};

  assign prod_fix  = neg_q ? -{p_hi, p_lo} : {p_hi, p_lo};
  assign q_fix     = neg_q ? -p_lo : p_lo;
  assign r_fix     = neg_r ? -p_hi : p_hi;

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    alu_res = '0;
    unique case (alu_op)
      OP_ADD:  alu_res = lvalue + rvalue;
      OP_SUB:  alu_res = lvalue - rvalue;
      OP_OR:   alu_res = lvalue | rvalue;
      OP_AND:  alu_res = lvalue & rvalue;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(lvalue) < $signed(rvalue))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (lvalue < rvalue)};
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (accept && is_iter)
                state_next = (is_div && rvalue == '0) ? S_FIX : S_ITER;
      S_ITER: if (count == '0) state_next = S_FIX;
      S_FIX:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (flush) state_next = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count       <= '0;
      opnd        <= '0;
      p_hi        <= '0;
      p_lo        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      op_div      <= 1'b0;
      dz          <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      result      <= '0;
      out_valid   <= 1'b0;
      div_by_zero <= 1'b0;
      bad_op      <= 1'b0;
    end else begin
      out_valid   <= 1'b0;
      div_by_zero <= 1'b0;
      bad_op      <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept && is_iter) begin
            count  <= CW'(WIDTH - 1);
            op_div <= is_div;
            neg_q  <= l_neg ^ r_neg;
            neg_r  <= l_neg;
            dz     <= 1'b0;
            p_hi   <= '0;
            if (is_mul) begin
              opnd <= l_mag;
              p_lo <= r_mag;
            end else begin
              opnd <= r_mag;
              p_lo <= l_mag;
            end
            // Divide by zero skips iteration; FIX then publishes these values as-is.
            if (is_div && rvalue == '0) begin
              p_hi  <= lvalue;
              p_lo  <= '1;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              dz    <= 1'b1;
            end
          end else if (accept) begin
            result    <= alu_res;
            out_valid <= 1'b1;
            bad_op    <= alu_op[3] & alu_op[2];
          end
        end
        S_ITER: if (!flush) begin
          count <= count - 1'b1;
          if (op_div) begin
            p_hi <= div_ge ? div_trial[WIDTH-1:0] : {p_hi[WIDTH-2:0], p_lo[WIDTH-1]};
            p_lo <= {p_lo[WIDTH-2:0], div_ge};
          end else begin
            {p_hi, p_lo} <= {mul_sum, p_lo[WIDTH-1:1]};
          end
        end
        S_FIX: if (!flush) begin
          out_valid   <= 1'b1;
          div_by_zero <= dz;
          if (op_div) begin
            hi     <= r_fix;
            lo     <= q_fix;
            result <= q_fix;
          end else begin
            hi     <= prod_fix[2*WIDTH-1:WIDTH];
            lo     <= prod_fix[WIDTH-1:0];
            result <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
